// File: rtl/fir_da_pkg.sv
// rtl/fir_da_pkg.sv - shared types and width helpers for the symmetric DA FIR
// Holds the control FSM state enum plus constant functions used to derive
// address, LUT and output widths from the tap count and data widths.
package fir_da_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        BUILD = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Coefficient index width; a single pair still needs a 1-bit port.
    function automatic int addr_w(input int k);
        return (clog2(k) < 1) ? 1 : clog2(k);
    endfunction

    // A LUT entry is the sum of up to K coefficients, plus one bit of headroom
    // so the sign-bit partial product can be negated without wrapping.
    function automatic int lut_w(input int coef_w, input int taps);
        return coef_w + clog2(taps / 2) + 1;
    endfunction

    function automatic int dout_w(input int din_w, input int coef_w, input int taps);
        return din_w + 1 + coef_w + clog2(taps / 2);
    endfunction

endpackage

// File: rtl/da_lut_builder.sv
// rtl/da_lut_builder.sv - coefficient store and distributed-arithmetic LUT rebuild
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   coef_we_i/addr/data   coefficient write (already gated to RUN by the top)
//   build_i               high for every BUILD cycle; one LUT entry per cycle
//   build_done_o          high in the cycle that writes the last entry
//   rd_addr_i/rd_data_o   NRD combinational LUT read ports
module da_lut_builder #(
    parameter int K      = 3,
    parameter int COEF_W = 17,
    parameter int LUT_W  = 20,
    parameter int AW     = 2,
    parameter int NRD    = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        coef_we_i,
    input  logic [AW-1:0]               coef_addr_i,
    input  logic [COEF_W-1:0]           coef_data_i,
    input  logic                        build_i,
    output logic                        build_done_o,
    input  logic [NRD-1:0][K-1:0]       rd_addr_i,
    output logic [NRD-1:0][LUT_W-1:0]   rd_data_o
);

    localparam int N = 1 << K;

    logic [K-1:0][COEF_W-1:0] coef_q;
    logic [K-1:0]             cnt_q;
    logic [N-1:0][LUT_W-1:0]  lut_q;
    logic [LUT_W-1:0]         entry_d;

    // Entry for address cnt_q: sum of the coefficients whose bit is set.
    always_comb begin
        entry_d = '0;
        for (int j = 0; j < K; j++) begin
            if (cnt_q[j]) entry_d = entry_d + LUT_W'($signed(coef_q[j]));
        end
    end

    // The K-bit counter wraps back to 0 after the last entry, ready for the next build.
    assign build_done_o = build_i && (cnt_q == {K{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q <= '0;
            cnt_q  <= '0;
            lut_q  <= '0;
        end else begin
            if (coef_we_i && (int'(coef_addr_i) < K)) coef_q[coef_addr_i] <= coef_data_i;
            if (build_i) begin
                lut_q[cnt_q] <= entry_d;
                cnt_q        <= cnt_q + K'(1);
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int b = 0; b < NRD; b++) rd_data_o[b] = lut_q[rd_addr_i[b]];
    end

endmodule

// File: rtl/da_fir_sym_prog.sv
// rtl/da_fir_sym_prog.sv - programmable symmetric distributed-arithmetic FIR
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_data/in_ready        sample handshake (ready only in RUN)
//   flush                            clears the delay line
//   coef_we/coef_addr/coef_data      coefficient write, honoured when coef_ready
//   coef_ready                       high only in RUN
//   out_valid/out_data               one result pulse per accepted sample, 4 cycles later
module da_fir_sym_prog
    import fir_da_pkg::*;
#(
    parameter int TAPS   = 6,
    parameter int DIN_W  = 12,
    parameter int COEF_W = 17,
    parameter int DOUT_W = dout_w(DIN_W, COEF_W, TAPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DIN_W-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [addr_w(TAPS/2)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]          coef_data,
    output logic                       coef_ready,
    output logic                       out_valid,
    output logic [DOUT_W-1:0]          out_data
);

    localparam int K     = TAPS / 2;
    localparam int AW    = addr_w(K);
    localparam int PW    = DIN_W + 1;
    localparam int LUT_W = lut_w(COEF_W, TAPS);

    state_e state_q, state_d;
    logic   build_en, build_done, accept;

    logic [TAPS-1:0][DIN_W-1:0] dl_q;      // dl_q[0] is the newest sample
    logic [K-1:0][PW-1:0]       pa_q;
    logic [PW-1:0][K-1:0]       rd_addr;
    logic [PW-1:0][LUT_W-1:0]   rd_data;
    logic [PW-1:0][LUT_W-1:0]   part_q;
    logic signed [DOUT_W-1:0]   tree_d, tree_q, ext;
    logic [3:0]                 vld_q;     // occupancy of stages 1..4
    logic                       out_valid_q;
    logic [DOUT_W-1:0]          out_data_q;

    assign accept = in_valid && in_ready;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (coef_we) state_d = DRAIN;
            DRAIN:   if (vld_q == '0) state_d = BUILD;
            BUILD:   if (build_done) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == RUN);
        coef_ready = (state_q == RUN);
        build_en   = (state_q == BUILD);
    end

    da_lut_builder #(
        .K      (K),
        .COEF_W (COEF_W),
        .LUT_W  (LUT_W),
        .AW     (AW),
        .NRD    (PW)
    ) u_lut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coef_we_i    (coef_we && coef_ready),
        .coef_addr_i  (coef_addr),
        .coef_data_i  (coef_data),
        .build_i      (build_en),
        .build_done_o (build_done),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data)
    );

    // ---------------- delay line ----------------
    // flush clears history; a sample accepted in the same cycle lands in the cleared line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q <= '0;
        end else if (flush) begin
            dl_q <= '0;
            if (accept) dl_q[0] <= in_data;
        end else if (accept) begin
            dl_q <= {dl_q[TAPS-2:0], in_data};
        end
    end

    // Bit-slice b of all pre-added pairs forms the LUT address for that weight.
    always_comb begin
        rd_addr = '0;
        for (int b = 0; b < PW; b++) begin
            for (int j = 0; j < K; j++) rd_addr[b][j] = pa_q[j][b];
        end
    end

    always_comb begin
        tree_d = '0;
        ext    = '0;
        for (int b = 0; b < PW; b++) begin
            ext    = DOUT_W'($signed(part_q[b]));
            tree_d = tree_d + (ext <<< b);
        end
    end

    // ---------------- datapath pipeline ----------------
    // Data stages run every cycle; vld_q tags which slots carry an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_q        <= '0;
            part_q      <= '0;
            tree_q      <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            vld_q <= {vld_q[2:0], accept};
            for (int i = 0; i < K; i++) begin
                pa_q[i] <= {dl_q[i][DIN_W-1], dl_q[i]}
                         + {dl_q[TAPS-1-i][DIN_W-1], dl_q[TAPS-1-i]};
            end
            // The pre-add MSB carries weight -2^DIN_W, so its partial is negated.
            for (int b = 0; b < PW; b++) begin
                part_q[b] <= (b == PW - 1) ? (LUT_W'(0) - rd_data[b]) : rd_data[b];
            end
            tree_q      <= tree_d;
            out_valid_q <= vld_q[3];
            if (vld_q[3]) out_data_q <= tree_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_da_fir_sym_prog.sv
// tb/tb_da_fir_sym_prog.sv - scoreboard bench for da_fir_sym_prog
module tb_da_fir_sym_prog;

    localparam int TAPS   = 6;
    localparam int DIN_W  = 12;
    localparam int COEF_W = 17;
    localparam int K      = TAPS / 2;
    localparam int AW     = 2;
    localparam int DOUT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [DIN_W-1:0]  in_data = '0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              coef_ready;
    logic              out_valid;
    logic [DOUT_W-1:0] out_data;

    da_fir_sym_prog dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint y;
        int     acc;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     last_acc = -100;
    int     hist[TAPS];
    int     coef[K];
    longint last_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: y[n] = sum_i c_i * (x[n-i] + x[n-TAPS+1+i]) over the model history.
    function automatic longint model_y();
        longint y;
        y = 0;
        for (int i = 0; i < K; i++) y += longint'(coef[i]) * longint'(hist[i] + hist[TAPS-1-i]);
        return y;
    endfunction

    // Monitor: pops one expectation per out_valid pulse; checks hold value otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%0d (cycle %0d)", $signed(out_data), cyc);
                end else begin
                    e = q.pop_front();
                    chk("out_data", $signed(out_data), e.y);
                    chk("latency", cyc - e.acc, 4);
                end
                last_out = $signed(out_data);
            end else begin
                chk("hold", $signed(out_data), last_out);
            end
        end
    end

    task automatic step(input bit v, input int d, input bit fl, input bit we,
                        input int addr, input int cval);
        bit   acc, wr;
        exp_t e;
        in_valid  = v;
        in_data   = d[DIN_W-1:0];
        flush     = fl;
        coef_we   = we;
        coef_addr = addr[AW-1:0];
        coef_data = cval[COEF_W-1:0];
        acc = v && in_ready;
        wr  = we && coef_ready;
        if (fl) foreach (hist[i]) hist[i] = 0;
        if (acc) begin
            for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0]  = d;
            e.y      = model_y();
            e.acc    = cyc + 1;
            last_acc = cyc + 1;
            q.push_back(e);
        end
        if (wr) coef[addr] = cval;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Busy window = DRAIN (until stages 1..4 are empty, at least one cycle) + 2^K BUILD cycles.
    task automatic load_coef(input int addr, input int cval, input bit v, input int d);
        int n, lo, rdy_hi, gap, exp_lo;
        n = 0;
        while (!coef_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        step(v, d, 0, 1, addr, cval);
        gap    = cyc - last_acc;
        exp_lo = (((5 - gap) > 1) ? (5 - gap) : 1) + (1 << K);
        lo     = 0;
        rdy_hi = 0;
        while (!coef_ready && lo < 100) begin
            if (in_ready) rdy_hi++;
            lo++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", lo, exp_lo);
        chk("in_ready_busy", rdy_hi, 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        coef_we  = 1'b0;
        q.delete();
        foreach (hist[i]) hist[i] = 0;
        foreach (coef[i]) coef[i] = 0;
        last_out = 0;
        last_acc = -100;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coef_ready", coef_ready, 1);
        rst_n = 1'b1;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    function automatic int rnd_coef();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Impulse response with the reference coefficient set.
        load_coef(0, 7567, 0, 0);
        load_coef(1, 20406, 0, 0);
        load_coef(2, 32768, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
        idle(6);

        // Full-scale steady inputs.
        for (int i = 0; i < 10; i++) step(1, 2047, 0, 0, 0, 0);
        idle(6);
        chk("settle_pos", last_out, 64'sd248673654);
        for (int i = 0; i < 10; i++) step(1, -2048, 0, 0, 0, 0);
        idle(6);
        chk("settle_neg", last_out, -64'sd248795136);

        // Every-other-cycle input.
        for (int i = 0; i < 10; i++) begin
            step(1, rnd_sample(), 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        idle(6);

        // Coefficient write with samples in flight and one coincident sample.
        for (int i = 0; i < 3; i++) step(1, rnd_sample(), 0, 0, 0, 0);
        load_coef(1, -12345, 1, rnd_sample());
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
        idle(6);

        // flush alone, then flush coincident with a sample.
        for (int i = 0; i < 5; i++) step(1, rnd_sample(), 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, rnd_sample(), 0, 0, 0, 0);
        step(1, 100, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        idle(6);

        // Reset while the LUT is being rebuilt.
        step(0, 0, 0, 1, 2, rnd_coef());
        idle(4);
        chk("mid_build_coef_ready", coef_ready, 0);
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        idle(6);
        load_coef(0, 5000, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
        idle(6);

        // Randomized traffic with extreme coefficients in the mix.
        load_coef(0, -65536, 0, 0);
        load_coef(1, rnd_coef(), 0, 0);
        load_coef(2, 65535, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? -2048 : rnd_sample(),
                 $urandom_range(0, 23) == 0,
                 $urandom_range(0, 39) == 0,
                 int'($urandom_range(0, K - 1)),
                 rnd_coef());
        end
        idle(10);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
